// File: rtl/nn_pkg.sv
// Shared types and default sizes for the classifier datapath.
package nn_pkg;

  localparam int DEF_N = 200;
  localparam int DEF_W = 16;

  typedef enum logic [1:0] {IDLE, SCAN, VALID} argmax_state_t;

  typedef logic signed [DEF_N-1:0] act_t;

endpackage

// File: rtl/dense_argmax.sv
// Classifier output stage: captures a signed activation vector, scans it one
// element per cycle and presents the winning index and score.
module dense_argmax
  import nn_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [N-1:0]  in_vec [W],
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IDX_W-1:0]     cls_idx,
  output logic signed [N-1:0]  cls_score,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output argmax_state_t        dbg_state
);

  typedef logic signed [N-1:0] elem_t;

  argmax_state_t    r_state;
  argmax_state_t    w_next;
  elem_t            r_buf [W];
  elem_t            r_best;
  logic [IDX_W-1:0] r_bidx;
  logic [IDX_W-1:0] r_cls_idx;
  elem_t            r_cls_score;

  logic             w_accept;
  logic             w_scan_last;
  elem_t            w_best_nxt;
  logic [IDX_W-1:0] w_bidx_nxt;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid holds until transfer.
  assign in_ready  = (r_state == IDLE) | ((r_state == VALID) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == VALID);
  assign busy      = (r_state != IDLE);
  assign cls_idx   = r_cls_idx;
  assign cls_score = r_cls_score;
  assign dbg_state = r_state;

  generate
    if (W > 1) begin : g_scan
      logic [IDX_W-1:0] r_i;
      logic             w_take;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_i <= '0;
        end else if (w_accept) begin
          r_i <= IDX_W'(1);
        end else if (r_state == SCAN) begin
          r_i <= r_i + IDX_W'(1);
        end
      end

      // Strict compare so the lowest index wins ties.
      assign w_take      = (r_buf[r_i] > r_best);
      assign w_scan_last = (r_i == IDX_W'(W - 1));
      assign w_best_nxt  = w_take ? r_buf[r_i] : r_best;
      assign w_bidx_nxt  = w_take ? r_i : r_bidx;
    end else begin : g_single
      assign w_scan_last = 1'b1;
      assign w_best_nxt  = r_best;
      assign w_bidx_nxt  = r_bidx;
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = (W == 1) ? VALID : SCAN;
      end
      SCAN: begin
        if (w_scan_last) w_next = VALID;
      end
      VALID: begin
        if (w_accept)       w_next = (W == 1) ? VALID : SCAN;
        else if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_best      <= '0;
      r_bidx      <= '0;
      r_cls_idx   <= '0;
      r_cls_score <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_best <= in_vec[0];
        r_bidx <= '0;
        if (W == 1) begin
          r_cls_idx   <= '0;
          r_cls_score <= in_vec[0];
        end
      end else if (r_state == SCAN) begin
        r_best <= w_best_nxt;
        r_bidx <= w_bidx_nxt;
        if (w_scan_last) begin
          r_cls_idx   <= w_bidx_nxt;
          r_cls_score <= w_best_nxt;
        end
      end
    end
  end

  // Vector storage needs no reset; it is only read after an accept fills it.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf <= in_vec;
  end

endmodule
